// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Purpose  : Iterative signed 32x32 multiplier / 32/32 divider producing the
//             HI/LO special-register pair. Operands are converted to
//             magnitudes when the operation is accepted. The core then runs
//             32 unsigned shift-add or restoring shift-subtract steps. One
//             final FIX cycle applies the sign rules.
//             Latency is a fixed 33 edges from the accepting edge to done.
//
//  Ports    : CLK          - clock, rising-edge active
//             RESET        - synchronous active-high reset
//             start        - request a new operation (ignored while busy)
//             ALU_control  - 4'b1011 signed mult, 4'b1101 signed div
//             A            - multiplicand / dividend
//             B            - multiplier / divisor
//             Hi           - product[63:32] / remainder
//             Lo           - product[31:0]  / quotient
//             busy         - operation in progress
//             done         - one-cycle strobe, Hi/Lo valid (HI/LO write enable)
//
//  Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [3:0]  ALU_control,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] OP_MULT   = 4'b1011;
  localparam logic [3:0] OP_DIV    = 4'b1101;
  localparam logic [5:0] LAST_ITER = 6'd31;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]  state_q,  state_d;
  logic [5:0]  cnt_q,    cnt_d;
  logic [31:0] opa_q,    opa_d;     // multiplicand (mult) or divisor (div) magnitude
  logic [63:0] acc_q,    acc_d;     // mult: {partial, multiplier}; div: {rem, quot}
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        is_div_q, is_div_d;
  logic        b_zero_q, b_zero_d;
  logic [31:0] hi_q,     hi_d;
  logic [31:0] lo_q,     lo_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic        w_go_mult;
  logic        w_go_div;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_acc;
  logic [32:0] w_div_diff;
  logic [63:0] w_div_acc;
  logic [63:0] w_prod_neg;
  logic [31:0] w_quot_neg;
  logic [31:0] w_rem_neg;

  assign w_go_mult = start && (ALU_control == OP_MULT);
  assign w_go_div  = start && (ALU_control == OP_DIV);

  // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
  assign w_a_mag = A[31] ? (~A + 32'd1) : A;
  assign w_b_mag = B[31] ? (~B + 32'd1) : B;

  // Shift-add step: conditionally add the multiplicand into the upper half,
  // then shift the whole accumulator right, keeping the carry.
  assign w_mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
  assign w_mul_acc = {w_mul_sum, acc_q[31:1]};

  // Restoring step on the left-shifted {rem, quot}. The running remainder is
  // always below 2^31 before the shift (it is smaller than a divisor of at
  // most 2^31, or holds fewer than 32 dividend bits when dividing by zero),
  // so acc_q[62:31] is the exact shifted remainder.
  assign w_div_diff = {1'b0, acc_q[62:31]} - {1'b0, opa_q};
  assign w_div_acc  = w_div_diff[32] ? {acc_q[62:0], 1'b0}
                                     : {w_div_diff[31:0], acc_q[30:0], 1'b1};

  assign w_prod_neg = ~acc_q + 64'd1;
  assign w_quot_neg = ~acc_q[31:0] + 32'd1;
  assign w_rem_neg  = ~acc_q[63:32] + 32'd1;

  // --------------------------------------------------------------------------
  // State register and all datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      opa_q    <= 32'd0;
      acc_q    <= 64'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_div_q <= 1'b0;
      b_zero_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      acc_q    <= acc_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      is_div_q <= is_div_d;
      b_zero_q <= b_zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_go_mult) begin
          state_d = S_MULT;
        end else if (w_go_div) begin
          state_d = S_DIV;
        end
      end
      S_MULT, S_DIV: begin
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath next-value logic
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    acc_d    = acc_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    is_div_d = is_div_q;
    b_zero_d = b_zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_go_mult || w_go_div) begin
          cnt_d    = 6'd0;
          sign_a_d = A[31];
          sign_b_d = B[31];
          is_div_d = w_go_div;
          b_zero_d = (B == 32'd0);
          busy_d   = 1'b1;
          // The operand that is consumed bit-serially sits in the low half
          // of the accumulator; the other one stays parallel in opa.
          if (w_go_div) begin
            opa_d = w_b_mag;
            acc_d = {32'd0, w_a_mag};
          end else begin
            opa_d = w_a_mag;
            acc_d = {32'd0, w_b_mag};
          end
        end
      end
      S_MULT: begin
        acc_d = w_mul_acc;
        cnt_d = cnt_q + 6'd1;
      end
      S_DIV: begin
        acc_d = w_div_acc;
        cnt_d = cnt_q + 6'd1;
      end
      S_FIX: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (is_div_q) begin
          // Dividing by zero leaves rem = |A|, so the dividend-sign rule
          // hands back A itself; only the quotient needs forcing.
          lo_d = b_zero_q ? 32'hFFFF_FFFF
                          : ((sign_a_q ^ sign_b_q) ? w_quot_neg : acc_q[31:0]);
          hi_d = sign_a_q ? w_rem_neg : acc_q[63:32];
        end else begin
          {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? w_prod_neg : acc_q;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire
